// File: rtl/reg_writeback.sv
// Write-side sequencer for the 15-entry register file: buffers producer write
// requests in a FIFO and issues one src_w/val write per cycle, splitting SP
// writes into sp_low/sp_high. Optional forwarding lookup: define HAZARD_FWD_EN.
module reg_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                         cpu_clk,
  input  logic                         cpu_rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [3:0]                   req_dst,
  input  logic [2*DATA_W-1:0]          req_data,
  input  logic                         req_wide,
  output logic                         we,
  output logic [3:0]                   src_w,
  output logic [DATA_W-1:0]            val,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err_wide
`ifdef HAZARD_FWD_EN
  ,
  input  logic [3:0]                   fwd_addr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [3:0] SP_LO = 4'hE;
  localparam logic [3:0] SP_HI = 4'hF;

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  typedef struct packed {
    logic [3:0]          dst;
    logic                wide;  // legal SP write: dst is sp_low
    logic [2*DATA_W-1:0] data;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              wr_entry;
  entry_t              head;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [3:0]          src_w_q, src_w_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic                err_wide_q, err_wide_d;
  logic                full, empty, accept, push, pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_dst != 4'h0);
  // The head is popped only from registered occupancy, so a fresh entry never bypasses.
  assign pop       = (state_q != WR_HI) && !empty;
  assign head      = mem_q[rd_ptr_q];

  assign wr_entry = '{dst: req_dst, wide: req_wide && (req_dst == SP_LO), data: req_data};

  assign err_wide_d = err_wide_q | (push && req_wide && (req_dst != SP_LO));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every signal written in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    src_w_d = 4'h0;
    val_d   = val_q;
    hi_d    = hi_q;
    case (state_q)
      WR_HI: begin
        we_d    = 1'b1;
        src_w_d = SP_HI;
        val_d   = hi_q;
        state_d = empty ? IDLE : WR_LO;
      end
      default: begin
        if (pop) begin
          we_d    = 1'b1;
          src_w_d = head.dst;
          val_d   = head.data[DATA_W-1:0];
          hi_d    = head.data[2*DATA_W-1:DATA_W];
          state_d = head.wide ? WR_HI : WR_LO;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      we_q       <= 1'b0;
      src_w_q    <= 4'h0;
      val_q      <= '0;
      hi_q       <= '0;
      err_wide_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      we_q       <= we_d;
      src_w_q    <= src_w_d;
      val_q      <= val_d;
      hi_q       <= hi_d;
      err_wide_q <= err_wide_d;
    end
  end

  // NOTE: storage array has no reset; occupancy and pointers alone decide which entries are live.
  always_ff @(posedge cpu_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign we       = we_q;
  assign src_w    = src_w_q;
  assign val      = val_q;
  assign count    = count_q;
  assign err_wide = err_wide_q;
  assign busy     = !empty || we_q || (state_q != IDLE);

`ifdef HAZARD_FWD_EN
  // Oldest candidate first so that newer matches override: pending sp_high, then head..tail.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != 4'h0) begin
      if ((state_q == WR_HI) && (fwd_addr == SP_HI)) begin
        fwd_hit  = 1'b1;
        fwd_data = hi_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) < count_q) begin
          if (mem_q[rd_ptr_q + PTR_W'(i)].dst == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_q[rd_ptr_q + PTR_W'(i)].data[DATA_W-1:0];
          end else if (mem_q[rd_ptr_q + PTR_W'(i)].wide && (fwd_addr == SP_HI)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_q[rd_ptr_q + PTR_W'(i)].data[2*DATA_W-1:DATA_W];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: stimulus pushes expected writes into a
// queue, an independent monitor pops and compares each write the DUT issues.
module tb_reg_writeback;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                 cpu_clk = 1'b0;
  logic                 cpu_rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [3:0]           req_dst;
  logic [2*DATA_W-1:0]  req_data;
  logic                 req_wide;
  logic                 we;
  logic [3:0]           src_w;
  logic [DATA_W-1:0]    val;
  logic                 busy;
  logic [CNT_W-1:0]     count;
  logic                 err_wide;
`ifdef HAZARD_FWD_EN
  logic [3:0]           fwd_addr;
  logic                 fwd_hit;
  logic [DATA_W-1:0]    fwd_data;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] exp_q [$];
  logic [19:0] mon_e;
  bit          saw_full = 1'b0;

  reg_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dst   (req_dst),
    .req_data  (req_data),
    .req_wide  (req_wide),
    .we        (we),
    .src_w     (src_w),
    .val       (val),
    .busy      (busy),
    .count     (count),
    .err_wide  (err_wide)
`ifdef HAZARD_FWD_EN
    ,
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must be the next expected one.
  always @(negedge cpu_clk) begin
    if (cpu_rst_n) begin
      check("ready_vs_count", req_ready, count != CNT_W'(DEPTH));
      check("count_bound", count <= CNT_W'(DEPTH), 1'b1);
      if (!req_ready) saw_full = 1'b1;
      if (we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", we, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", src_w, mon_e[19:16]);
          check("write_data", val, mon_e[15:0]);
        end
      end else begin
        check("idle_src_w", src_w, 4'h0);
      end
    end
  end

  task automatic sync();
    @(posedge cpu_clk);
    #1;
  endtask

  // Offer one request; returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] dst, input logic [31:0] data, input logic wide);
    int waited = 0;
    req_valid = 1'b1;
    req_dst   = dst;
    req_data  = data;
    req_wide  = wide;
    @(negedge cpu_clk);
    while (!req_ready && waited < 50) begin
      @(negedge cpu_clk);
      waited++;
    end
    if (!req_ready) begin
      check("send_ready_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
    end else begin
      if (dst != 4'h0) exp_q.push_back({dst, data[15:0]});
      if (dst == 4'hE && wide) exp_q.push_back({4'hF, data[31:16]});
      @(posedge cpu_clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    do begin
      @(negedge cpu_clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 100);
    check(name, exp_q.size(), 0);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0;
    req_dst   = 4'h0;
    req_data  = '0;
    req_wide  = 1'b0;
`ifdef HAZARD_FWD_EN
    fwd_addr  = 4'h0;
`endif
    cpu_rst_n = 1'b1;
    #1 cpu_rst_n = 1'b0;
    #1;
    check("rst_we", we, 1'b0);
    check("rst_src_w", src_w, 4'h0);
    check("rst_val", val, 16'h0);
    check("rst_count", count, 0);
    check("rst_err_wide", err_wide, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    repeat (2) @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    sync();

    // Single narrow write: one-cycle gap, then the write, then idle with val held.
    send(4'h3, 32'h0000_1234, 1'b0);
    @(negedge cpu_clk);
    check("t1_no_bypass_we", we, 1'b0);
    check("t1_count", count, 1);
    @(negedge cpu_clk);
    check("t1_we", we, 1'b1);
    check("t1_src_w", src_w, 4'h3);
    check("t1_val", val, 16'h1234);
    @(negedge cpu_clk);
    check("t1_we_off", we, 1'b0);
    check("t1_val_hold", val, 16'h1234);
    drain("t1_drain");

    // Wide SP write: sp_low then sp_high on consecutive cycles.
    sync();
    send(4'hE, 32'hABCD_8FFF, 1'b1);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    check("t2_lo_src", src_w, 4'hE);
    check("t2_lo_val", val, 16'h8FFF);
    check("t2_lo_busy", busy, 1'b1);
    @(negedge cpu_clk);
    check("t2_hi_src", src_w, 4'hF);
    check("t2_hi_val", val, 16'hABCD);
    check("t2_hi_busy", busy, 1'b1);
    @(negedge cpu_clk);
    check("t2_done_we", we, 1'b0);
    check("t2_done_busy", busy, 1'b0);
    drain("t2_drain");

    // Back-pressure: wide writes drain at half rate, so the FIFO fills.
    sync();
    saw_full = 1'b0;
    for (int i = 0; i < 4; i++) send(4'hE, {16'hA000 + 16'(i), 16'h0A00 + 16'(i)}, 1'b1);
    for (int i = 1; i <= 6; i++) send(4'(i), {16'hFFFF, 16'h0100 + 16'(i)}, 1'b0);
    drain("t3_drain");
    check("t3_saw_full", saw_full, 1'b1);

    // Discard and illegal wide.
    sync();
    send(4'h0, 32'hDEAD_BEEF, 1'b0);
    repeat (3) @(negedge cpu_clk);
    check("t4_discard_count", count, 0);
    check("t4_err_clear", err_wide, 1'b0);
    sync();
    send(4'h5, 32'h1111_2222, 1'b1);
    @(negedge cpu_clk);
    check("t4_err_set", err_wide, 1'b1);
    drain("t4_drain");
    repeat (3) @(negedge cpu_clk);
    check("t4_err_sticky", err_wide, 1'b1);

`ifdef HAZARD_FWD_EN
    // Forwarding: two queued writes to r7, with a pending sp_high behind val.
    sync();
    send(4'hE, 32'h5555_6666, 1'b1);
    send(4'hE, 32'h7777_8888, 1'b1);
    send(4'h7, 32'h0000_0001, 1'b0);
    send(4'h7, 32'h0000_0002, 1'b0);
    check("t5_count", count, 2);
    fwd_addr = 4'h7;
    #1;
    check("t5_r7_hit", fwd_hit, 1'b1);
    check("t5_r7_data", fwd_data, 16'h0002);
    fwd_addr = 4'hF;
    #1;
    check("t5_sphi_hit", fwd_hit, 1'b1);
    check("t5_sphi_data", fwd_data, 16'h7777);
    fwd_addr = 4'hE;
    #1;
    check("t5_val_not_fwd", fwd_hit, 1'b0);
    fwd_addr = 4'h0;
    #1;
    check("t5_zero_miss", fwd_hit, 1'b0);
    drain("t5_drain");
    fwd_addr = 4'h7;
    #1;
    check("t5_after_miss", fwd_hit, 1'b0);
    fwd_addr = 4'h0;
`endif

    // Reset while sp_high is pending and two entries are queued.
    sync();
    send(4'hE, 32'h1234_5678, 1'b1);
    send(4'hE, 32'h9ABC_DEF0, 1'b1);
    send(4'h2, 32'h0000_0222, 1'b0);
    send(4'h3, 32'h0000_0333, 1'b0);
    check("t6_pre_count", count, 2);
    check("t6_pre_src", src_w, 4'hE);
    check("t6_pre_err", err_wide, 1'b1);
    #1 cpu_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_we", we, 1'b0);
    check("t6_rst_src", src_w, 4'h0);
    check("t6_rst_val", val, 16'h0);
    check("t6_rst_count", count, 0);
    check("t6_rst_err", err_wide, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    repeat (2) @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    repeat (6) @(negedge cpu_clk);
    check("t6_post_count", count, 0);
    check("t6_post_busy", busy, 1'b0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
